regfile_scoreboard: RTL and testbench

Parametrised register file for the datapath: configurable word width and depth, one write port and two registered read ports, plus a per-register pending (scoreboard) bit for tracking in-flight producers. It replaces the fixed 8-bit file in the decode/execute path. Operand reads return data one cycle after the address is presented, together with that register's pending status.

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_read_port.sv | 74 +++++++
 rtl/regfile_scoreboard.sv | 114 +++++++++++
 tb/tb_regfile_scoreboard.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the parametrised register file with scoreboard.
//   DEFAULT_DATA_WIDTH : default register word width in bits
//   DEFAULT_ADDR_WIDTH : default address width (depth = 2**ADDR_WIDTH)
//   reg_reset_value()  : reset contents of register 'index' for a word of
//                        'width' bits (index truncated to width bits)
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 4;

    // Register i resets to i. Only the low 'width' bits survive, so a narrow
    // file wraps (e.g. register 20 of a 4-bit file resets to 4). Callers cast
    // the 32-bit result to their word width, which zero-extends wide words.
    function automatic logic [31:0] reg_reset_value(input int unsigned index,
                                                    input int unsigned width);
        logic [31:0] mask;
        if (width >= 32) begin
            mask = '1;
        end else begin
            mask = (32'd1 << width) - 32'd1;
        end
        return index & mask;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// One registered read port of the register file. Selects a word and its
// pending bit by address and loads them into output registers when enabled;
// the outputs hold while read_enable is low.
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   - a read sampled on the same edge as a write/reserve to the same
//               address returns the post-update data and pending bit
//   undefined - the read returns the pre-edge contents
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   read_enable         : sample the port on the next rising edge
//   read_address        : register being read
//   regs, pending       : current storage and pending bits from the top
//   write_*, reserve_*  : same-cycle update, only present with bypass
//   out_data            : registered read data
//   out_pending         : registered pending bit of the sampled address
// -----------------------------------------------------------------------------
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    localparam int DEPTH = 2 ** ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             read_enable,
    input  logic [ADDR_WIDTH-1:0]            read_address,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs,
    input  logic [DEPTH-1:0]                 pending,
`ifdef REGFILE_BYPASS_EN
    input  logic                             write_enable,
    input  logic [ADDR_WIDTH-1:0]            write_address,
    input  logic [DATA_WIDTH-1:0]            write_data,
    input  logic                             reserve_enable,
    input  logic [ADDR_WIDTH-1:0]            reserve_address,
`endif
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_pending
);

    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_pending;

    // Address mux. With bypass, a same-address write forwards its data and
    // clears pending; a same-address reserve then sets pending again, so the
    // reserve-wins rule of the storage is reproduced on the forwarded value.
    always_comb begin
        sel_data    = regs[read_address];
        sel_pending = pending[read_address];
`ifdef REGFILE_BYPASS_EN
        if (write_enable && (write_address == read_address)) begin
            sel_data    = write_data;
            sel_pending = 1'b0;
        end
        if (reserve_enable && (reserve_address == read_address)) begin
            sel_pending = 1'b1;
        end
`endif
    end

    // Enable-gated output registers; they hold their value when not enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data    <= '0;
            out_pending <= 1'b0;
        end else if (read_enable) begin
            out_data    <= sel_data;
            out_pending <= sel_pending;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Parametrised register file with one write port, two registered read ports
// and a per-register pending (scoreboard) bit for in-flight producers.
// Optional feature macro: REGFILE_BYPASS_EN (same-edge write/reserve bypass
// into the read ports; see regfile_read_port).
// Ports:
//   CLK, RST                        : clock, asynchronous active-high reset
//   WriteEnable/Address/Data        : write port, also clears pending
//   ReserveEnable/ReserveAddress    : sets the pending bit of a register
//   ReadEnable1/2, ReadAddress1/2   : read port controls
//   OutData1/2, OutPending1/2       : registered read results
//   PendingVector                   : all pending bits, straight from flops
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    localparam int DEPTH = 2 ** ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WriteEnable,
    input  logic [ADDR_WIDTH-1:0] WriteAddress,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  ReserveEnable,
    input  logic [ADDR_WIDTH-1:0] ReserveAddress,
    input  logic                  ReadEnable1,
    input  logic [ADDR_WIDTH-1:0] ReadAddress1,
    input  logic                  ReadEnable2,
    input  logic [ADDR_WIDTH-1:0] ReadAddress2,
    output logic [DATA_WIDTH-1:0] OutData1,
    output logic [DATA_WIDTH-1:0] OutData2,
    output logic                  OutPending1,
    output logic                  OutPending2,
    output logic [DEPTH-1:0]      PendingVector
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
    logic [DEPTH-1:0]                 pending;

    // Storage: each register resets to its own index, truncated to the word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= DATA_WIDTH'(reg_reset_value(i, DATA_WIDTH));
            end
        end else if (WriteEnable) begin
            regs[WriteAddress] <= WriteData;
        end
    end

    // Pending bits: a completing write clears, an issuing reserve sets. The
    // reserve assignment comes last so it wins on a shared address, since the
    // new producer is queued behind the one that just completed.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending <= '0;
        end else begin
            if (WriteEnable) begin
                pending[WriteAddress] <= 1'b0;
            end
            if (ReserveEnable) begin
                pending[ReserveAddress] <= 1'b1;
            end
        end
    end

    assign PendingVector = pending;

    regfile_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_read_port1 (
        .clk            (CLK),
        .rst            (RST),
        .read_enable    (ReadEnable1),
        .read_address   (ReadAddress1),
        .regs           (regs),
        .pending        (pending),
`ifdef REGFILE_BYPASS_EN
        .write_enable   (WriteEnable),
        .write_address  (WriteAddress),
        .write_data     (WriteData),
        .reserve_enable (ReserveEnable),
        .reserve_address(ReserveAddress),
`endif
        .out_data       (OutData1),
        .out_pending    (OutPending1)
    );

    regfile_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_read_port2 (
        .clk            (CLK),
        .rst            (RST),
        .read_enable    (ReadEnable2),
        .read_address   (ReadAddress2),
        .regs           (regs),
        .pending        (pending),
`ifdef REGFILE_BYPASS_EN
        .write_enable   (WriteEnable),
        .write_address  (WriteAddress),
        .write_data     (WriteData),
        .reserve_enable (ReserveEnable),
        .reserve_address(ReserveAddress),
`endif
        .out_data       (OutData2),
        .out_pending    (OutPending2)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
// Self-checking bench for regfile_scoreboard. A default-size instance is
// driven by directed and random stimulus and compared with an array-based
// model; a second instance (DATA_WIDTH=4, ADDR_WIDTH=5) covers wrap-around
// reset values and dual same-address reads. Honours REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NREG = 16;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    always #5 CLK = ~CLK;

    // Default-size instance
    logic          we = 1'b0, rsv = 1'b0, re1 = 1'b0, re2 = 1'b0;
    logic [AW-1:0] wa = '0, rsa = '0, ra1 = '0, ra2 = '0;
    logic [DW-1:0] wd = '0;
    logic [DW-1:0] od1, od2;
    logic          op1, op2;
    logic [NREG-1:0] pv;

    // Narrow/deep instance
    logic        s_we = 1'b0, s_rsv = 1'b0, s_re1 = 1'b0, s_re2 = 1'b0;
    logic [4:0]  s_wa = '0, s_rsa = '0, s_ra1 = '0, s_ra2 = '0;
    logic [3:0]  s_wd = '0;
    logic [3:0]  s_od1, s_od2;
    logic        s_op1, s_op2;
    logic [31:0] s_pv;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the default instance
    int m_regs [NREG];
    bit m_pend [NREG];
    int m_od1, m_od2;
    bit m_op1, m_op2;

    regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RST(RST),
        .WriteEnable(we), .WriteAddress(wa), .WriteData(wd),
        .ReserveEnable(rsv), .ReserveAddress(rsa),
        .ReadEnable1(re1), .ReadAddress1(ra1),
        .ReadEnable2(re2), .ReadAddress2(ra2),
        .OutData1(od1), .OutData2(od2),
        .OutPending1(op1), .OutPending2(op2),
        .PendingVector(pv)
    );

    regfile_scoreboard #(.DATA_WIDTH(4), .ADDR_WIDTH(5)) dut_small (
        .CLK(CLK), .RST(RST),
        .WriteEnable(s_we), .WriteAddress(s_wa), .WriteData(s_wd),
        .ReserveEnable(s_rsv), .ReserveAddress(s_rsa),
        .ReadEnable1(s_re1), .ReadAddress1(s_ra1),
        .ReadEnable2(s_re2), .ReadAddress2(s_ra2),
        .OutData1(s_od1), .OutData2(s_od2),
        .OutPending1(s_op1), .OutPending2(s_op2),
        .PendingVector(s_pv)
    );

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = i % 256;
            m_pend[i] = 1'b0;
        end
        m_od1 = 0; m_od2 = 0; m_op1 = 1'b0; m_op2 = 1'b0;
    endtask

    // One clock edge of the model using the currently driven inputs.
    task automatic model_edge();
        int post_regs [NREG];
        bit post_pend [NREG];
        post_regs = m_regs;
        post_pend = m_pend;
        if (we) begin
            post_regs[wa] = int'(wd);
            post_pend[wa] = 1'b0;
        end
        if (rsv) post_pend[rsa] = 1'b1;
`ifdef REGFILE_BYPASS_EN
        if (re1) begin m_od1 = post_regs[ra1]; m_op1 = post_pend[ra1]; end
        if (re2) begin m_od2 = post_regs[ra2]; m_op2 = post_pend[ra2]; end
`else
        if (re1) begin m_od1 = m_regs[ra1]; m_op1 = m_pend[ra1]; end
        if (re2) begin m_od2 = m_regs[ra2]; m_op2 = m_pend[ra2]; end
`endif
        m_regs = post_regs;
        m_pend = post_pend;
    endtask

    function automatic logic [NREG-1:0] model_pvec();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic idle();
        we = 1'b0; rsv = 1'b0; re1 = 1'b0; re2 = 1'b0;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        idle();
        RST = 1'b0;
        #1;
        RST = 1'b1;
        #11;
        checks += 5;
        if (od1 !== 8'd0) begin errors++; $display("[TB] FAIL reset_od1: got %h expected 00", od1); end
        if (od2 !== 8'd0) begin errors++; $display("[TB] FAIL reset_od2: got %h expected 00", od2); end
        if (op1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_op1: got %b expected 0", op1); end
        if (op2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_op2: got %b expected 0", op2); end
        if (pv !== 16'd0) begin errors++; $display("[TB] FAIL reset_pv: got %h expected 0000", pv); end
        RST = 1'b0;
        model_reset();
    endtask

    task automatic test_read_basic();
        idle();
        re1 = 1'b1; ra1 = 4'd5;
        re2 = 1'b1; ra2 = 4'd15;
        cycle();
        checks += 4;
        if (od1 !== 8'd5)  begin errors++; $display("[TB] FAIL read5_od1: got %0d expected 5", od1); end
        if (od2 !== 8'd15) begin errors++; $display("[TB] FAIL read15_od2: got %0d expected 15", od2); end
        if (op1 !== 1'b0)  begin errors++; $display("[TB] FAIL read5_op1: got %b expected 0", op1); end
        if (op2 !== 1'b0)  begin errors++; $display("[TB] FAIL read15_op2: got %b expected 0", op2); end
        re1 = 1'b0; ra1 = 4'd9;
        cycle();
        checks++;
        if (od1 !== 8'd5) begin errors++; $display("[TB] FAIL hold_od1: got %0d expected 5", od1); end
    endtask

    task automatic test_write_bypass();
        logic [DW-1:0] exp_same;
`ifdef REGFILE_BYPASS_EN
        exp_same = 8'hA5;
`else
        exp_same = 8'h03;
`endif
        idle();
        we = 1'b1; wa = 4'd3; wd = 8'hA5;
        re1 = 1'b1; ra1 = 4'd3;
        cycle();
        checks++;
        if (od1 !== exp_same) begin errors++; $display("[TB] FAIL same_edge_read: got %h expected %h", od1, exp_same); end
        we = 1'b0;
        cycle();
        checks++;
        if (od1 !== 8'hA5) begin errors++; $display("[TB] FAIL next_read: got %h expected a5", od1); end
    endtask

    task automatic test_pending();
        idle();
        rsv = 1'b1; rsa = 4'd7;
        cycle();
        rsv = 1'b0;
        re1 = 1'b1; ra1 = 4'd7;
        cycle();
        checks += 2;
        if (op1 !== 1'b1)   begin errors++; $display("[TB] FAIL reserve_op1: got %b expected 1", op1); end
        if (pv[7] !== 1'b1) begin errors++; $display("[TB] FAIL reserve_pv7: got %b expected 1", pv[7]); end
        re1 = 1'b0;
        we = 1'b1; wa = 4'd7; wd = 8'h11;
        cycle();
        we = 1'b0;
        re1 = 1'b1; ra1 = 4'd7;
        cycle();
        checks += 3;
        if (od1 !== 8'h11)  begin errors++; $display("[TB] FAIL complete_od1: got %h expected 11", od1); end
        if (op1 !== 1'b0)   begin errors++; $display("[TB] FAIL complete_op1: got %b expected 0", op1); end
        if (pv[7] !== 1'b0) begin errors++; $display("[TB] FAIL complete_pv7: got %b expected 0", pv[7]); end
    endtask

    task automatic test_reserve_write_same();
        idle();
        rsv = 1'b1; rsa = 4'd2;
        we = 1'b1; wa = 4'd2; wd = 8'h3C;
        cycle();
        checks++;
        if (pv[2] !== 1'b1) begin errors++; $display("[TB] FAIL rsv_wins_pv2: got %b expected 1", pv[2]); end
        idle();
        re1 = 1'b1; ra1 = 4'd2;
        cycle();
        checks += 2;
        if (od1 !== 8'h3C) begin errors++; $display("[TB] FAIL rsv_wins_od1: got %h expected 3c", od1); end
        if (op1 !== 1'b1)  begin errors++; $display("[TB] FAIL rsv_wins_op1: got %b expected 1", op1); end
    endtask

    task automatic test_async_reset();
        idle();
        rsv = 1'b1; rsa = 4'd9;
        we = 1'b1; wa = 4'd4; wd = 8'h77;
        re1 = 1'b1; ra1 = 4'd4;
        re2 = 1'b1; ra2 = 4'd9;
        cycle();
        cycle();
        checks += 2;
        if (od1 !== 8'h77) begin errors++; $display("[TB] FAIL pre_reset_od1: got %h expected 77", od1); end
        if (pv[9] !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_pv9: got %b expected 1", pv[9]); end
        #2;
        RST = 1'b1;
        #1;
        checks += 5;
        if (od1 !== 8'd0)  begin errors++; $display("[TB] FAIL async_od1: got %h expected 00", od1); end
        if (od2 !== 8'd0)  begin errors++; $display("[TB] FAIL async_od2: got %h expected 00", od2); end
        if (op1 !== 1'b0)  begin errors++; $display("[TB] FAIL async_op1: got %b expected 0", op1); end
        if (op2 !== 1'b0)  begin errors++; $display("[TB] FAIL async_op2: got %b expected 0", op2); end
        if (pv !== 16'd0)  begin errors++; $display("[TB] FAIL async_pv: got %h expected 0000", pv); end
        @(posedge CLK);
        #1;
        checks += 2;
        if (pv !== 16'd0) begin errors++; $display("[TB] FAIL held_reset_pv: got %h expected 0000", pv); end
        if (od1 !== 8'd0) begin errors++; $display("[TB] FAIL held_reset_od1: got %h expected 00", od1); end
        #2;
        RST = 1'b0;
        model_reset();
        idle();
        re1 = 1'b1; ra1 = 4'd4;
        re2 = 1'b1; ra2 = 4'd9;
        cycle();
        checks += 3;
        if (od1 !== 8'd4)  begin errors++; $display("[TB] FAIL post_reset_reg4: got %h expected 04", od1); end
        if (op2 !== 1'b0)  begin errors++; $display("[TB] FAIL post_reset_op9: got %b expected 0", op2); end
        if (pv !== 16'd0)  begin errors++; $display("[TB] FAIL post_reset_pv: got %h expected 0000", pv); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            we  = 1'($urandom_range(1));
            rsv = 1'($urandom_range(3) == 0);
            re1 = 1'($urandom_range(3) != 0);
            re2 = 1'($urandom_range(3) != 0);
            wa  = 4'($urandom_range(15));
            wd  = 8'($urandom);
            // Narrow the address range now and then to force collisions
            if ($urandom_range(1) == 1) begin
                rsa = wa; ra1 = wa;
                ra2 = 4'($urandom_range(15));
            end else begin
                rsa = 4'($urandom_range(15));
                ra1 = 4'($urandom_range(15));
                ra2 = 4'($urandom_range(15));
            end
            cycle();
            checks += 5;
            if (od1 !== DW'(m_od1)) begin errors++; $display("[TB] FAIL rand_od1 step %0d: got %h expected %h", n, od1, DW'(m_od1)); end
            if (od2 !== DW'(m_od2)) begin errors++; $display("[TB] FAIL rand_od2 step %0d: got %h expected %h", n, od2, DW'(m_od2)); end
            if (op1 !== m_op1) begin errors++; $display("[TB] FAIL rand_op1 step %0d: got %b expected %b", n, op1, m_op1); end
            if (op2 !== m_op2) begin errors++; $display("[TB] FAIL rand_op2 step %0d: got %b expected %b", n, op2, m_op2); end
            if (pv !== model_pvec()) begin errors++; $display("[TB] FAIL rand_pv step %0d: got %h expected %h", n, pv, model_pvec()); end
        end
        idle();
    endtask

    task automatic test_param_sweep();
        logic [4:0] a;
        logic [3:0] v;
        s_re1 = 1'b1; s_ra1 = 5'd20;
        s_re2 = 1'b1; s_ra2 = 5'd20;
        @(posedge CLK);
        #1;
        checks += 4;
        if (s_od1 !== 4'd4)  begin errors++; $display("[TB] FAIL small_reg20_p1: got %0d expected 4", s_od1); end
        if (s_od2 !== 4'd4)  begin errors++; $display("[TB] FAIL small_reg20_p2: got %0d expected 4", s_od2); end
        if (s_op1 !== 1'b0)  begin errors++; $display("[TB] FAIL small_op1: got %b expected 0", s_op1); end
        if (s_pv !== 32'd0)  begin errors++; $display("[TB] FAIL small_pv: got %h expected 0", s_pv); end
        s_ra1 = 5'd31; s_ra2 = 5'd16;
        @(posedge CLK);
        #1;
        checks += 2;
        if (s_od1 !== 4'd15) begin errors++; $display("[TB] FAIL small_reg31: got %0d expected 15", s_od1); end
        if (s_od2 !== 4'd0)  begin errors++; $display("[TB] FAIL small_reg16: got %0d expected 0", s_od2); end
        for (int n = 0; n < 8; n++) begin
            a = 5'($urandom_range(31));
            v = 4'($urandom);
            s_re1 = 1'b0; s_re2 = 1'b0;
            s_we = 1'b1; s_wa = a; s_wd = v;
            @(posedge CLK);
            #1;
            s_we = 1'b0;
            s_re1 = 1'b1; s_ra1 = a;
            s_re2 = 1'b1; s_ra2 = a;
            @(posedge CLK);
            #1;
            checks += 2;
            if (s_od1 !== v) begin errors++; $display("[TB] FAIL small_dual_p1 addr %0d: got %h expected %h", a, s_od1, v); end
            if (s_od2 !== v) begin errors++; $display("[TB] FAIL small_dual_p2 addr %0d: got %h expected %h", a, s_od2, v); end
        end
        s_re1 = 1'b0; s_re2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_bypass();
        test_pending();
        test_reserve_write_same();
        test_async_reset();
        test_random();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
